prbs_ber_sequencer: RTL and testbench

- Synthesizable on-chip replacement for the bench-driven BER bring-up sequence.
- Runs the full test unattended:
  - loads every FFE weight over an ack-based handshake, for N_LANES lanes by FFE_LENGTH taps;
  - holds and releases the PRBS checker and CDR resets;
  - waits a programmable lock interval, then runs the checker for a programmable interval;
  - freezes the checker, latches error and total counts, and grades pass/fail against programmable thresholds.
- Sits between the JTAG config registers / emulator controller and the FFE weight-manager, CDR and PRBS checker.

---
 rtl/prbs_ber_sequencer_pkg.sv | 29 ++
 rtl/prbs_ber_sequencer_if.sv | 22 ++
 rtl/prbs_ber_sequencer_wme_if.sv | 145 ++++++++++++++
 rtl/prbs_ber_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_prbs_ber_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_ber_sequencer_pkg.sv
// Shared types and constants for the PRBS BER bring-up sequencer.
package prbs_seq_pack;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PRBS_REL = 4'd1,
    ST_LOAD_RD  = 4'd2,
    ST_LOAD_REQ = 4'd3,
    ST_LOAD_REL = 4'd4,
    ST_CDR_RST  = 4'd5,
    ST_LOCK     = 4'd6,
    ST_RUN      = 4'd7,
    ST_FREEZE   = 4'd8,
    ST_CHECK    = 4'd9,
    ST_DONE     = 4'd10
  } prbs_seq_state_t;

  localparam logic [1:0] PRBS_MODE_IDLE   = 2'd0;
  localparam logic [1:0] PRBS_MODE_RUN    = 2'd2;
  localparam logic [1:0] PRBS_MODE_FREEZE = 2'd3;

  localparam int unsigned WDOG_WIDTH = 16;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prbs_ber_sequencer_if.sv
// Coefficient-RAM read port plus 4-phase weight-manager write handshake.
interface prbs_ber_sequencer_if #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WEIGHT_W = 10
);
  logic [ADDR_W-1:0]   coef_raddr;
  logic [WEIGHT_W-1:0] coef_rdata;
  logic [ADDR_W:0]     wme_ffe_inst;
  logic [WEIGHT_W-1:0] wme_ffe_data;
  logic                wme_ffe_exec;
  logic                wme_ffe_ack;

  modport master (
    output coef_raddr, wme_ffe_inst, wme_ffe_data, wme_ffe_exec,
    input  coef_rdata, wme_ffe_ack
  );

  modport slave (
    input  coef_raddr, wme_ffe_inst, wme_ffe_data, wme_ffe_exec,
    output coef_rdata, wme_ffe_ack
  );
endinterface

// File: rtl/prbs_ber_sequencer_wme_if.sv
// Walks every {lane, tap}, reads the weight RAM and writes it over the ack handshake.
// PRBS_SEQ_ACK_TIMEOUT_EN adds a handshake watchdog.
module prbs_seq_wme_if
  import prbs_seq_pack::*;
#(
  parameter int unsigned N_LANES      = 16,
  parameter int unsigned FFE_LENGTH   = 10,
  parameter int unsigned WEIGHT_WIDTH = 10
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            load_start_c,
  prbs_ber_sequencer_if.master bus,
  output logic            load_done_c,
  output logic            load_timeout_c,
  output prbs_seq_state_t phase
);

  localparam int unsigned LW = idx_width(N_LANES);
  localparam int unsigned DW = idx_width(FFE_LENGTH);

  prbs_seq_state_t         phase_q, phase_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [DW-1:0]           tap_q, tap_d;
  logic                    rd_wait_q, rd_wait_d;
  logic [LW+DW-1:0]        raddr_q, raddr_d;
  logic [LW+DW:0]          inst_q, inst_d;
  logic [WEIGHT_WIDTH-1:0] data_q, data_d;
  logic                    exec_q, exec_d;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
  logic [WDOG_WIDTH-1:0]   wd_q, wd_d;
`endif

  logic last_c;
  assign last_c = (lane_q == LW'(N_LANES - 1)) && (tap_q == DW'(FFE_LENGTH - 1));

  always_comb begin
    phase_d        = phase_q;
    lane_d         = lane_q;
    tap_d          = tap_q;
    rd_wait_d      = rd_wait_q;
    raddr_d        = raddr_q;
    inst_d         = inst_q;
    data_d         = data_q;
    exec_d         = exec_q;
    load_done_c    = 1'b0;
    load_timeout_c = 1'b0;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
    wd_d           = '0;
`endif
    case (phase_q)
      // First cycle presents the address, second captures the RAM output.
      ST_LOAD_RD: begin
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          rd_wait_d = 1'b0;
          data_d    = bus.coef_rdata;
          inst_d    = {1'b0, lane_q, tap_q};
          exec_d    = 1'b1;
          phase_d   = ST_LOAD_REQ;
        end
      end
      ST_LOAD_REQ: begin
        if (bus.wme_ffe_ack) begin
          exec_d  = 1'b0;
          phase_d = ST_LOAD_REL;
        end
      end
      ST_LOAD_REL: begin
        if (!bus.wme_ffe_ack) begin
          if (last_c) begin
            load_done_c = 1'b1;
            phase_d     = ST_IDLE;
          end else begin
            if (tap_q == DW'(FFE_LENGTH - 1)) begin
              tap_d  = '0;
              lane_d = LW'(lane_q + LW'(1));
            end else begin
              tap_d  = DW'(tap_q + DW'(1));
            end
            raddr_d = {lane_d, tap_d};
            phase_d = ST_LOAD_RD;
          end
        end
      end
      default: begin
        if (load_start_c) begin
          lane_d    = '0;
          tap_d     = '0;
          raddr_d   = '0;
          rd_wait_d = 1'b0;
          phase_d   = ST_LOAD_RD;
        end
      end
    endcase
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
    if (phase_q == ST_LOAD_REQ || phase_q == ST_LOAD_REL) begin
      if (wd_q == {WDOG_WIDTH{1'b1}}) begin
        exec_d         = 1'b0;
        phase_d        = ST_IDLE;
        load_done_c    = 1'b0;
        load_timeout_c = 1'b1;
      end else begin
        wd_d = WDOG_WIDTH'(wd_q + WDOG_WIDTH'(1));
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      phase_q   <= ST_IDLE;
      lane_q    <= '0;
      tap_q     <= '0;
      rd_wait_q <= 1'b0;
      raddr_q   <= '0;
      inst_q    <= '0;
      data_q    <= '0;
      exec_q    <= 1'b0;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      phase_q   <= phase_d;
      lane_q    <= lane_d;
      tap_q     <= tap_d;
      rd_wait_q <= rd_wait_d;
      raddr_q   <= raddr_d;
      inst_q    <= inst_d;
      data_q    <= data_d;
      exec_q    <= exec_d;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign bus.coef_raddr   = raddr_q;
  assign bus.wme_ffe_inst = inst_q;
  assign bus.wme_ffe_data = data_q;
  assign bus.wme_ffe_exec = exec_q;
  assign phase            = phase_q;

endmodule

// File: rtl/prbs_ber_sequencer.sv
// Unattended BER bring-up: FFE weight load, checker/CDR reset sequencing, timed run and grading.
// PRBS_SEQ_ACK_TIMEOUT_EN enables the weight-handshake watchdog and the ack_timeout port.
module prbs_ber_sequencer
  import prbs_seq_pack::*;
#(
  parameter int unsigned N_LANES       = 16,
  parameter int unsigned FFE_LENGTH    = 10,
  parameter int unsigned WEIGHT_WIDTH  = 10,
  parameter int unsigned WAIT_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH     = 64,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [WAIT_WIDTH-1:0] lock_cycles,
  input  logic [WAIT_WIDTH-1:0] run_cycles,
  input  logic [CNT_WIDTH-1:0]  min_total_bits,
  input  logic [CNT_WIDTH-1:0]  max_err_bits,
  prbs_ber_sequencer_if.master  wme_bus,
  output logic                  prbs_rstb,
  output logic [1:0]            prbs_checker_mode,
  output logic                  cdr_rstb,
  input  logic [CNT_WIDTH-1:0]  err_bits,
  input  logic [CNT_WIDTH-1:0]  total_bits,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_latched,
  output logic [CNT_WIDTH-1:0]  total_latched,
  output logic [3:0]            state_dbg
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
  , output logic                ack_timeout
`endif
);

  localparam logic [WAIT_WIDTH-1:0] SETTLE_LAST = WAIT_WIDTH'(SETTLE_CYCLES - 1);

  prbs_seq_state_t       state_q, state_d;
  prbs_seq_state_t       load_phase;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WAIT_WIDTH-1:0] lock_s_q, lock_s_d;
  logic [WAIT_WIDTH-1:0] run_s_q, run_s_d;
  logic                  prbs_rstb_q, prbs_rstb_d;
  logic [1:0]            mode_q, mode_d;
  logic                  cdr_rstb_q, cdr_rstb_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [CNT_WIDTH-1:0]  tot_q, tot_d;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
  logic                  ack_to_q, ack_to_d;
`endif
  logic                  load_start_c, load_done_c, load_timeout_c;
  logic                  go_run_c;

  prbs_seq_wme_if #(
    .N_LANES      (N_LANES),
    .FFE_LENGTH   (FFE_LENGTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_wme (
    .clk            (clk),
    .rstb           (rstb),
    .load_start_c   (load_start_c),
    .bus            (wme_bus),
    .load_done_c    (load_done_c),
    .load_timeout_c (load_timeout_c),
    .phase          (load_phase)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_s_d     = lock_s_q;
    run_s_d      = run_s_q;
    prbs_rstb_d  = prbs_rstb_q;
    mode_d       = mode_q;
    cdr_rstb_d   = cdr_rstb_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    tot_d        = tot_q;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
    ack_to_d     = ack_to_q;
`endif
    load_start_c = 1'b0;
    go_run_c     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          tot_d       = '0;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
          ack_to_d    = 1'b0;
`endif
          busy_d      = 1'b1;
          lock_s_d    = lock_cycles;
          run_s_d     = run_cycles;
          prbs_rstb_d = 1'b0;
          cdr_rstb_d  = 1'b0;
          mode_d      = PRBS_MODE_IDLE;
          cnt_d       = SETTLE_LAST;
          state_d     = ST_PRBS_REL;
        end
      end
      ST_PRBS_REL: begin
        prbs_rstb_d = 1'b1;
        if (cnt_q == '0) begin
          load_start_c = 1'b1;
          state_d      = ST_LOAD_RD;
        end else begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end
      end
      ST_LOAD_RD: begin
        if (load_timeout_c) begin
          pass_d   = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
          ack_to_d = 1'b1;
`endif
          state_d  = ST_DONE;
        end else if (load_done_c) begin
          cdr_rstb_d = 1'b0;
          cnt_d      = SETTLE_LAST;
          state_d    = ST_CDR_RST;
        end
      end
      ST_CDR_RST: begin
        if (cnt_q == '0) begin
          cdr_rstb_d = 1'b1;
          if (lock_s_q == '0) begin
            go_run_c = 1'b1;
          end else begin
            cnt_d   = lock_s_q - WAIT_WIDTH'(1);
            state_d = ST_LOCK;
          end
        end else begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end
      end
      ST_LOCK: begin
        if (cnt_q == '0) go_run_c = 1'b1;
        else             cnt_d = cnt_q - WAIT_WIDTH'(1);
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          mode_d  = PRBS_MODE_FREEZE;
          cnt_d   = SETTLE_LAST;
          state_d = ST_FREEZE;
        end else begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end
      end
      ST_FREEZE: begin
        if (cnt_q == '0) begin
          err_d   = err_bits;
          tot_d   = total_bits;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end
      end
      ST_CHECK: begin
        pass_d  = (tot_q >= min_total_bits) && (err_q <= max_err_bits);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared RUN entry; a zero run interval goes straight to freeze.
    if (go_run_c) begin
      if (run_s_q == '0) begin
        mode_d  = PRBS_MODE_FREEZE;
        cnt_d   = SETTLE_LAST;
        state_d = ST_FREEZE;
      end else begin
        mode_d  = PRBS_MODE_RUN;
        cnt_d   = run_s_q - WAIT_WIDTH'(1);
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lock_s_q    <= '0;
      run_s_q     <= '0;
      prbs_rstb_q <= 1'b0;
      mode_q      <= PRBS_MODE_IDLE;
      cdr_rstb_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      tot_q       <= '0;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
      ack_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_s_q    <= lock_s_d;
      run_s_q     <= run_s_d;
      prbs_rstb_q <= prbs_rstb_d;
      mode_q      <= mode_d;
      cdr_rstb_q  <= cdr_rstb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      tot_q       <= tot_d;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
      ack_to_q    <= ack_to_d;
`endif
    end
  end

  assign prbs_rstb         = prbs_rstb_q;
  assign prbs_checker_mode = mode_q;
  assign cdr_rstb          = cdr_rstb_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign err_latched       = err_q;
  assign total_latched     = tot_q;
  // The load sub-FSM owns the LOAD_* encodings while the weight walk is active.
  assign state_dbg = (state_q == ST_LOAD_RD) ? 4'(load_phase) : 4'(state_q);
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
  assign ack_timeout       = ack_to_q;
`endif

endmodule

// File: tb/tb_prbs_ber_sequencer.sv
// Directed bench for prbs_ber_sequencer: RAM, weight-manager and checker models plus linear checks.
module tb_prbs_ber_sequencer;

  localparam int unsigned NL = 4;
  localparam int unsigned FL = 3;
  localparam int unsigned WW = 10;
  localparam int unsigned TW = 32;
  localparam int unsigned CW = 64;

  logic          clk = 1'b0;
  logic          rstb;
  logic          start;
  logic [TW-1:0] lock_cycles, run_cycles;
  logic [CW-1:0] min_total_bits, max_err_bits;
  logic          prbs_rstb, cdr_rstb, busy, done, pass;
  logic [1:0]    prbs_checker_mode;
  logic [CW-1:0] err_bits, total_bits, err_latched, total_latched;
  logic [3:0]    state_dbg;
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
  logic          ack_timeout;
`endif

  prbs_ber_sequencer_if #(.ADDR_W(4), .WEIGHT_W(WW)) bif ();

  prbs_ber_sequencer #(
    .N_LANES(NL), .FFE_LENGTH(FL), .WEIGHT_WIDTH(WW),
    .WAIT_WIDTH(TW), .CNT_WIDTH(CW), .SETTLE_CYCLES(8)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start),
    .lock_cycles(lock_cycles), .run_cycles(run_cycles),
    .min_total_bits(min_total_bits), .max_err_bits(max_err_bits),
    .wme_bus(bif.master),
    .prbs_rstb(prbs_rstb), .prbs_checker_mode(prbs_checker_mode), .cdr_rstb(cdr_rstb),
    .err_bits(err_bits), .total_bits(total_bits),
    .busy(busy), .done(done), .pass(pass),
    .err_latched(err_latched), .total_latched(total_latched),
    .state_dbg(state_dbg)
`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
    , .ack_timeout(ack_timeout)
`endif
  );

  always #5 clk = ~clk;

  // Coefficient RAM: RAM[a] = a, one-cycle read latency.
  always @(posedge clk) bif.coef_rdata <= WW'(bif.coef_raddr);

  // Weight manager: ack two cycles after exec, released once exec drops.
  logic ack_hold = 1'b0;
  int   ack_dly;
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bif.wme_ffe_ack <= 1'b0;
      ack_dly         <= 0;
    end else if (bif.wme_ffe_ack) begin
      if (!bif.wme_ffe_exec) bif.wme_ffe_ack <= 1'b0;
    end else if (bif.wme_ffe_exec && !ack_hold) begin
      if (ack_dly == 1) begin
        bif.wme_ffe_ack <= 1'b1;
        ack_dly         <= 0;
      end else begin
        ack_dly <= ack_dly + 1;
      end
    end else begin
      ack_dly <= 0;
    end
  end

  // PRBS checker: one bit per run cycle, first n_inject run cycles carry an error.
  int            n_inject = 0;
  int            inj_cnt;
  logic [CW-1:0] err_m, tot_m;
  always @(posedge clk) begin
    if (!prbs_rstb) begin
      err_m   <= '0;
      tot_m   <= '0;
      inj_cnt <= 0;
    end else if (prbs_checker_mode == 2'd2) begin
      tot_m <= tot_m + 64'd1;
      if (inj_cnt < n_inject) begin
        err_m   <= err_m + 64'd1;
        inj_cnt <= inj_cnt + 1;
      end
    end
  end
  assign err_bits   = err_m;
  assign total_bits = tot_m;

  // Write log, run-cycle counter and exec-before-ack monitor.
  logic [4:0]  wr_inst [128];
  logic [9:0]  wr_data [128];
  int          wr_n = 0;
  int          run_cyc = 0;
  int          early_drop = 0;
  logic        exec_d1;
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      exec_d1 <= 1'b0;
    end else begin
      exec_d1 <= bif.wme_ffe_exec;
      if (bif.wme_ffe_exec && !exec_d1 && wr_n < 128) begin
        wr_inst[wr_n] <= bif.wme_ffe_inst;
        wr_data[wr_n] <= bif.wme_ffe_data;
        wr_n          <= wr_n + 1;
      end
      if (exec_d1 && !bif.wme_ffe_exec && !bif.wme_ffe_ack) early_drop <= early_drop + 1;
      if (prbs_checker_mode == 2'd2) run_cyc <= run_cyc + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_wait", 64'(done), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int base);
    chk({tag, "_nwr"}, 64'(wr_n - base), 64'd12);
    for (int l = 0; l < int'(NL); l++) begin
      for (int t = 0; t < int'(FL); t++) begin
        chk({tag, "_inst"}, 64'(wr_inst[base + l*int'(FL) + t]), 64'(l*4 + t));
        chk({tag, "_data"}, 64'(wr_data[base + l*int'(FL) + t]), 64'(l*4 + t));
      end
    end
  endtask

  int base, rbase, k;

  initial begin
    rstb = 1'b0; start = 1'b0;
    lock_cycles = 32'd100; run_cycles = 32'd500;
    min_total_bits = 64'd400; max_err_bits = 64'd0;
    #1;
    chk("rst_exec", 64'(bif.wme_ffe_exec), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_prbs_rstb", 64'(prbs_rstb), 64'd0);
    chk("rst_cdr_rstb", 64'(cdr_rstb), 64'd0);
    chk("rst_mode", 64'(prbs_checker_mode), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    chk("rst_err", err_latched, 64'd0);
    chk("rst_tot", total_latched, 64'd0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Clean run: full load, 500-cycle run, no errors.
    base = wr_n; rbase = run_cyc;
    pulse_start();
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done(5000);
    check_writes("t1", base);
    chk("t1_early", 64'(early_drop), 64'd0);
    chk("t1_runcyc", 64'(run_cyc - rbase), 64'd500);
    chk("t1_tot", total_latched, 64'd500);
    chk("t1_err", err_latched, 64'd0);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_mode", 64'(prbs_checker_mode), 64'd3);
    chk("t1_state", 64'(state_dbg), 64'd10);
    chk("t1_cdr", 64'(cdr_rstb), 64'd1);
    chk("t1_prbs", 64'(prbs_rstb), 64'd1);

    // Three errors against max 2; restart from DONE, start and interval change mid-run ignored.
    n_inject = 3; max_err_bits = 64'd2;
    repeat (3) @(negedge clk);
    rbase = run_cyc;
    pulse_start();
    chk("t2_done_clr", 64'(done), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    k = 0;
    while (prbs_checker_mode != 2'd2 && k < 3000) begin @(negedge clk); k++; end
    chk("t2_in_run", 64'(prbs_checker_mode), 64'd2);
    repeat (10) @(negedge clk);
    run_cycles = 32'd50;
    pulse_start();
    chk("t2_busy_run", 64'(busy), 64'd1);
    wait_done(5000);
    chk("t2_runcyc", 64'(run_cyc - rbase), 64'd500);
    chk("t2_tot", total_latched, 64'd500);
    chk("t2_err", err_latched, 64'd3);
    chk("t2_pass", 64'(pass), 64'd0);

    // Same errors against max 3 passes.
    max_err_bits = 64'd3; run_cycles = 32'd500;
    @(negedge clk);
    pulse_start();
    wait_done(5000);
    chk("t3_err", err_latched, 64'd3);
    chk("t3_pass", 64'(pass), 64'd1);

    // Reset while a weight request is outstanding, then reload from (0,0).
    n_inject = 0;
    base = wr_n;
    pulse_start();
    k = 0;
    while (!(bif.wme_ffe_exec && (wr_n - base) >= 5) && k < 3000) begin @(negedge clk); k++; end
    chk("t4_exec_hi", 64'(bif.wme_ffe_exec), 64'd1);
    #2 rstb = 1'b0;
    #1;
    chk("t4_exec", 64'(bif.wme_ffe_exec), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_prbs", 64'(prbs_rstb), 64'd0);
    chk("t4_cdr", 64'(cdr_rstb), 64'd0);
    chk("t4_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    lock_cycles = 32'd0; run_cycles = 32'd20; min_total_bits = 64'd10; max_err_bits = 64'd0;
    repeat (2) @(negedge clk);
    base = wr_n; rbase = run_cyc;
    pulse_start();
    wait_done(5000);
    check_writes("t4", base);
    chk("t4_runcyc", 64'(run_cyc - rbase), 64'd20);
    chk("t4_tot", total_latched, 64'd20);
    chk("t4_pass", 64'(pass), 64'd1);

`ifdef PRBS_SEQ_ACK_TIMEOUT_EN
    // Weight manager never acknowledges: watchdog aborts the load.
    ack_hold = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_done(70000);
    chk("t5_exec", 64'(bif.wme_ffe_exec), 64'd0);
    chk("t5_ackto", 64'(ack_timeout), 64'd1);
    chk("t5_pass", 64'(pass), 64'd0);
    chk("t5_state", 64'(state_dbg), 64'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
